// File: rtl/tl_ul_sram_responder.sv
// TL-UL manager endpoint over a word-addressed 32-bit SRAM with a one-entry D register (1-cycle latency).
// Optional: define TL_UL_SRAM_RESPONDER_BACKPRESSURE_EN for LFSR-driven a_ready stalls.
module tl_ul_sram_responder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       SOURCE_W  = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned       DEPTH     = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [2:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [3:0]          a_mask,
  input  logic [31:0]         a_data,
  input  logic                a_corrupt,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_param,
  output logic [2:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_sink,
  output logic                d_denied,
  output logic [31:0]         d_data,
  output logic                d_corrupt
);
  localparam int unsigned       IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH * 4);

  typedef enum logic [2:0] {
    PUT_FULL    = 3'd0,
    PUT_PARTIAL = 3'd1,
    GET         = 3'd4
  } a_op_e;

  typedef enum logic [2:0] {
    ACCESS_ACK      = 3'd0,
    ACCESS_ACK_DATA = 3'd1
  } d_op_e;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] off;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       rdata;
  logic [1:0]        align_mask;
  logic [3:0]        full_mask;
  logic              in_range, aligned, op_ok, legal, is_get, accept;
  logic              unused_a_corrupt;

  // Corrupt write data is still committed; TL-UL leaves interpretation to the client.
  assign unused_a_corrupt = a_corrupt;

`ifdef TL_UL_SRAM_RESPONDER_BACKPRESSURE_EN
  logic [15:0] lfsr;

  always_ff @(posedge clock) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  assign a_ready = !reset && (!d_valid || d_ready) && !lfsr[0];
`else
  assign a_ready = !reset && (!d_valid || d_ready);
`endif

  assign accept = a_valid && a_ready;
  assign is_get = (a_opcode == GET);

  always_comb begin
    off      = a_address - BASE_ADDR;
    in_range = (a_address >= BASE_ADDR) && (off < SPAN);
    case (a_size)
      3'd0:    begin align_mask = 2'b00; full_mask = 4'b0001 << a_address[1:0]; end
      3'd1:    begin align_mask = 2'b01; full_mask = 4'b0011 << a_address[1:0]; end
      default: begin align_mask = 2'b11; full_mask = 4'b1111;                   end
    endcase
    aligned = (a_address[1:0] & align_mask) == 2'b00;
    op_ok   = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL) || (a_opcode == GET);
    legal   = op_ok && (a_param == 3'd0) && (a_size <= 3'd2) && aligned && in_range &&
              ((a_opcode != PUT_FULL) || (a_mask == full_mask));
    idx     = off[IDX_W+1:2];
    rdata   = mem[idx];
  end

  always_ff @(posedge clock) begin
    if (accept && legal && !is_get) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (a_mask[i]) mem[idx][8*i +: 8] <= a_data[8*i +: 8];
      end
    end
  end

  // Accept wins over consume so a new beat replaces the one leaving in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      d_valid   <= 1'b0;
      d_opcode  <= '0;
      d_size    <= '0;
      d_source  <= '0;
      d_denied  <= 1'b0;
      d_data    <= '0;
      d_corrupt <= 1'b0;
    end else if (accept) begin
      d_valid   <= 1'b1;
      d_opcode  <= is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
      d_size    <= a_size;
      d_source  <= a_source;
      d_denied  <= !legal;
      d_data    <= (legal && is_get) ? rdata : '0;
      d_corrupt <= !legal && is_get;
    end else if (d_ready) begin
      d_valid   <= 1'b0;
    end
  end

  assign d_param = '0;
  assign d_sink  = 1'b0;

endmodule

// File: doc/tl_ul_sram_responder.md
Name: tl_ul_sram_responder

Overview:
- TileLink-UL manager (responder) endpoint. Accepts single-beat A-channel Get/PutFullData/PutPartialData from a client and returns AccessAckData/AccessAck on the D channel.
- Backed by a word-addressed 32-bit storage array.
- Sits behind the client-side A/D queues that the TL monitor checks, and serves as scratchpad/test target in the E21 testbench.
- One-entry D output register gives a fixed 1-cycle latency. The block is fully pipelined when d_ready is held high.

Parameters:
- ADDR_W, 32, A-channel address width.
- SOURCE_W, 4, source ID width; echoed on d_source.
- BASE_ADDR, 32'h8000_0000, base of the decoded region.
- DEPTH, 1024, number of 32-bit words; must be a power of 2.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- a_valid  in  1  A beat valid.
- a_ready  out  1  A beat accepted when a_valid&&a_ready.
- a_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get.
- a_param  in  3  must be 0.
- a_size  in  3  log2 bytes.
- a_source  in  SOURCE_W  request ID.
- a_address  in  ADDR_W  byte address.
- a_mask  in  4  byte lanes.
- a_data  in  32  write data.
- a_corrupt  in  1  write data corrupt.
- d_valid  out  1  D beat valid.
- d_ready  in  1  D beat consumed.
- d_opcode  out  3  0=AccessAck, 1=AccessAckData.
- d_param  out  2  always 0.
- d_size  out  3  echo of a_size.
- d_source  out  SOURCE_W  echo of a_source.
- d_sink  out  1  always 0.
- d_denied  out  1  request rejected.
- d_data  out  32  read data; 0 for AccessAck or denied.
- d_corrupt  out  1  data corrupt.

Behaviour:
Reset:
- d_valid=0; d_opcode, d_size, d_source, d_denied, d_data, d_corrupt all 0.
- Storage array is not reset.
- Reset asserted mid-transaction drops any pending D beat. The A beat in that cycle is not accepted.

Handshake:
- a_ready = !reset && (!d_valid || d_ready), subject to the optional feature.
- a_ready does not depend on a_valid.
- Accepting an A beat at edge N presents its D beat from edge N to N+1; latency is exactly 1 cycle.
- D fields stay stable while d_valid && !d_ready.
- Simultaneous D consume and A accept in the same cycle: d_valid stays 1 with the new beat, giving back-to-back throughput of 1/cycle.
- d_valid drops only when consumed with no new accept.

Decode (computed on the accepted A beat):
- off = a_address - BASE_ADDR.
- in_range = a_address >= BASE_ADDR && off < DEPTH*4.
- aligned = (a_address & ((1<<a_size)-1)) == 0.
- legal = opcode in {0,1,4} && a_param==0 && a_size<=2 && aligned && in_range.
- PutFull additionally requires the mask to be full for the size/offset; otherwise the request is illegal.
- Illegal request: no storage access. Response carries d_denied=1, d_data=0, d_corrupt=1 if the opcode was Get, else 0. d_opcode is still derived from a_opcode: Get→1, else 0.
- Word index = off[log2(DEPTH)+1:2].

Get:
- Storage is read combinationally at accept and the full 32-bit word is registered into d_data. The client extracts the lanes.
- d_opcode=1.

PutFull / PutPartial:
- Only bytes with a_mask[i]=1 are written, at the accept edge.
- d_opcode=0, d_data=0.
- If a_corrupt=1, the write is still performed, with d_corrupt=0 and d_denied=0, per TL-UL semantics.

Read-after-write:
- A Get accepted the cycle after a Put to the same word returns the new data; storage is written at the Put accept edge.

Optional Feature:
- Macro TL_UL_SRAM_RESPONDER_BACKPRESSURE_EN.
- When defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle and is seeded to 16'hACE1 on reset. a_ready is additionally ANDed with !lfsr[0] to stress client stall paths. The LFSR never gates d_valid, and the ordering and latency rules above are otherwise unchanged.
- When undefined: no LFSR logic exists, and a_ready follows the base equation exactly.

Test Plan:
1. Reset held 3 cycles with a_valid=1 → a_ready=0, d_valid=0; first cycle after reset → a_ready=1.
2. PutFull addr 0x8000_0010, mask 4'hF, data 0xDEADBEEF, source 3; then Get same addr, size 2, source 5 → first D: opcode 0, source 3, denied 0; second D: opcode 1, source 5, data 0xDEADBEEF, each exactly 1 cycle after accept.
3. PutPartial addr 0x8000_0010, mask 4'b0010, data 0x0000_5500, then Get → data 0xDEAD55EF.
4. Get addr 0x8000_1000 (out of range, DEPTH=1024) → d_denied=1, d_corrupt=1, d_data=0. Get addr 0x8000_0002 size 2 (misaligned) → d_denied=1. Storage unchanged.
5. Back-to-back Gets with d_ready=1 for 8 cycles → 8 consecutive D beats, d_valid continuously 1. Then d_ready=0 → a_ready=0 next cycle and D fields hold until d_ready=1.
6. With TL_UL_SRAM_RESPONDER_BACKPRESSURE_EN defined: run 200 random legal requests → a_ready low on some cycles. Every request still answered in order with correct data and 1-cycle latency from its accept.
